// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first a programmable
// number of times, with optional idle gaps, behind a start/busy/done handshake.
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             data,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] shreg;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [BIT_W-1:0] bit_cnt;

    // NOTE: every register here is updated with <= so all branches see the
    // pre-edge values; blocking assignments would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pat_q   <= '0;
            shreg   <= '0;
            rep_cnt <= '0;
            gap_q   <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            data    <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort && repeat_n != '0) begin
                        pat_q   <= pattern;
                        rep_cnt <= repeat_n;
                        gap_q   <= gap_len;
                        shreg   <= pattern << 1;
                        bit_cnt <= '0;
                        data    <= pattern[PAT_W-1];
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state <= IDLE;
                        data  <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (bit_cnt != LAST_BIT) begin
                        data    <= shreg[PAT_W-1];
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + BIT_ONE;
                    end else if (rep_cnt == REP_ONE) begin
                        rep_cnt <= '0;
                        state   <= IDLE;
                        data    <= 1'b0;
                        valid   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt - REP_ONE;
                        bit_cnt <= '0;
                        if (gap_q == '0) begin
                            // Back-to-back repetition: first bit follows the last with no bubble.
                            data  <= pat_q[PAT_W-1];
                            shreg <= pat_q << 1;
                        end else begin
                            state   <= GAP;
                            data    <= 1'b0;
                            valid   <= 1'b0;
                            gap_cnt <= gap_q - GAP_ONE;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        state   <= SEND;
                        data    <= pat_q[PAT_W-1];
                        shreg   <= pat_q << 1;
                        bit_cnt <= '0;
                        valid   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench: directed scenarios then random traffic, compared cycle by
// cycle against a stream model that expands each accepted request into its output.
module tb_seq_pattern_gen;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] repeat_n = '0;
    logic [GAP_W-1:0] gap_len = '0;
    logic             abort = 1'b0;
    logic             data, valid, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic data;
        logic valid;
        logic busy;
        logic done;
    } out_t;

    out_t cur = '0;
    out_t exp_q[$];

    seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .repeat_n(repeat_n), .gap_len(gap_len), .abort(abort),
        .data(data), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
        end
    endtask

    // Whole transmission as seen after each successive edge following the accepting one.
    task automatic build(input logic [PAT_W-1:0] p, input int r, input int g);
        for (int k = 0; k < r; k++) begin
            for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back('{p[i], 1'b1, 1'b1, 1'b0});
            if (k < r - 1)
                for (int j = 0; j < g; j++) exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
        end
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic cycle(input logic s, input logic [PAT_W-1:0] p, input int r, input int g,
                         input logic a, input logic rst, input string tag);
        @(negedge clk);
        start = s; pattern = p; repeat_n = CNT_W'(r); gap_len = GAP_W'(g);
        abort = a; reset = rst;
        if (rst) exp_q.delete();
        else if (a && cur.busy) exp_q.delete();
        else if (s && !a && r != 0 && !cur.busy) build(p, r, g);
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : out_t'('0);
        @(posedge clk);
        #1;
        check({tag, ".data"},  data,  cur.data);
        check({tag, ".valid"}, valid, cur.valid);
        check({tag, ".busy"},  busy,  cur.busy);
        check({tag, ".done"},  done,  cur.done);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 0, 0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        cycle(1'b0, '0, 0, 0, 1'b0, 1'b1, "reset");
        cycle(1'b0, '0, 0, 0, 1'b0, 1'b1, "reset");
        idle(2, "post_reset");

        // Single repetition of 1010
        cycle(1'b1, 4'b1010, 1, 0, 1'b0, 1'b0, "s1_start");
        idle(7, "s1");

        // Three repetitions with two-cycle gaps
        cycle(1'b1, 4'b1010, 3, 2, 1'b0, 1'b0, "s2_start");
        idle(19, "s2");

        // Two back-to-back repetitions
        cycle(1'b1, 4'b1010, 2, 0, 1'b0, 1'b0, "s3_start");
        idle(10, "s3");

        // repeat_n = 0 is rejected
        cycle(1'b1, 4'b1111, 0, 3, 1'b0, 1'b0, "s4_rep0");
        idle(3, "s4_rep0");

        // start while busy is ignored; start in the done cycle is accepted
        cycle(1'b1, 4'b1010, 1, 0, 1'b0, 1'b0, "s4_start");
        cycle(1'b1, 4'b1100, 2, 1, 1'b0, 1'b0, "s4_busy");
        idle(2, "s4_busy");
        cycle(1'b0, '0, 0, 0, 1'b0, 1'b0, "s4_last");
        cycle(1'b1, 4'b0110, 1, 0, 1'b0, 1'b0, "s4_done_start");
        idle(7, "s4_second");

        // Abort at bit 2 of repetition 1
        cycle(1'b1, 4'b1010, 3, 0, 1'b0, 1'b0, "s5_start");
        idle(5, "s5");
        cycle(1'b0, '0, 0, 0, 1'b1, 1'b0, "s5_abort");
        idle(8, "s5_after");

        // Abort during GAP
        cycle(1'b1, 4'b1011, 2, 3, 1'b0, 1'b0, "s5g_start");
        idle(4, "s5g");
        cycle(1'b0, '0, 0, 0, 1'b1, 1'b0, "s5g_abort");
        idle(8, "s5g_after");

        // start with abort in IDLE is ignored
        cycle(1'b1, 4'b1010, 1, 0, 1'b1, 1'b0, "s5_idle_abort");
        idle(3, "s5_idle_abort");

        // Reset mid-SEND with start and abort, then a fresh scenario 1
        cycle(1'b1, 4'b1010, 2, 1, 1'b0, 1'b0, "s6_start");
        idle(2, "s6");
        cycle(1'b1, 4'b0101, 1, 0, 1'b1, 1'b1, "s6_reset");
        idle(2, "s6_after");
        cycle(1'b1, 4'b1010, 1, 0, 1'b0, 1'b0, "s6_fresh");
        idle(7, "s6_fresh");

        // Maximum repetition count
        cycle(1'b1, 4'b1001, 255, 0, 1'b0, 1'b0, "max_start");
        idle(1025, "max");

        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 2) == 0, PAT_W'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 39) == 0,
                  $urandom_range(0, 149) == 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern transmitter for the bit-stream detector path. It loads a PAT_W-bit pattern (1010 for the detector bench), then shifts it out MSB-first, one bit per clock. It repeats the pattern a programmable number of times, with optional idle gap cycles between repetitions. It drives the `data` input of the sequence detectors and reports progress through a start/busy/done handshake.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits (≥2)
- CNT_W, 8, width of repetition counter
- GAP_W, 4, width of inter-repetition gap length

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; only reset in block
- start  input  1  request transmission; sampled only when busy=0
- pattern  input  PAT_W  bit pattern, sent MSB first; latched on accepted start
- repeat_n  input  CNT_W  number of pattern repetitions; latched on accepted start
- gap_len  input  GAP_W  idle cycles between repetitions; latched on accepted start
- abort  input  1  cancel transmission in progress
- data  output  1  serial bit; 0 whenever valid=0
- valid  output  1  data carries a pattern bit this cycle
- busy  output  1  transmission in progress
- done  output  1  one-cycle pulse after the last bit of the last repetition

## Operation
- One clock (clk); reset is synchronous and active-high.
- All outputs are registered. Reset forces state IDLE, data=0, valid=0, busy=0, done=0, and clears counters.
- Reset has priority over abort. Abort has priority over start and normal progress.
- FSM states: IDLE, SEND, GAP.
  - IDLE:
    - start=1 with repeat_n≠0: latch pattern, repeat_n and gap_len; go to SEND. valid=1, data=pattern[PAT_W-1] and busy=1 are visible after that edge.
    - start=1 with repeat_n=0: ignored; no busy, no done.
  - SEND:
    - Each cycle presents the next bit of the shift register.
    - A bit counter runs 0..PAT_W-1. On its last value, the repetition counter decrements.
    - If repetitions remain and gap_len=0: reload the shift register and continue in SEND. Repetitions go out back-to-back with no bubble.
    - If repetitions remain and gap_len>0: go to GAP.
    - If this was the last repetition: go to IDLE. valid=0, busy=0, done=1.
  - GAP:
    - valid=0, data=0, busy=1 for exactly gap_len cycles.
    - Then reload the shift register and go to SEND.
    - No gap after the final repetition.
- done is high for exactly one cycle. It never coincides with valid=1 from the same transmission.
- start while busy=1 is ignored. A changed pattern, repeat_n or gap_len during transmission has no effect.
- start is accepted in the cycle done=1 (state is IDLE, busy=0). A new transmission's first bit then follows the done cycle.
- abort=1 in SEND or GAP: next edge goes to IDLE with data=0, valid=0, busy=0, done=0.
- abort=1 in IDLE: no effect, and start is ignored that cycle.

## Timing
- Accepted start at edge E0: bit i of repetition 0 appears after edge E0+i.
- For R=repeat_n and G=gap_len:
  - valid is high for R·PAT_W cycles.
  - busy is high for R·PAT_W + (R-1)·G cycles.
  - done appears after edge E0 + R·PAT_W + (R-1)·G.
- Maximum R is 2^CNT_W−1. The counter never wraps, because R=0 is rejected at start.
- Minimum spacing between the done pulses of two 1-repetition transmissions: PAT_W+1 cycles.
- Reset mid-transmission takes effect at the next edge; partial patterns are not completed.

## Test plan
- pattern=1010, repeat_n=1, gap_len=0, start at E0 -> data=1,0,1,0 with valid=1 after E0..E0+3; after E0+4: valid=0, busy=0, done=1 for one cycle. A detector fed with data pulses tick exactly once.
- pattern=1010, repeat_n=3, gap_len=2 -> data 1010 00 1010 00 1010; valid high 12 cycles, busy high 16 cycles, single done after E0+16.
- pattern=1010, repeat_n=2, gap_len=0 -> 10101010 contiguous, valid high 8 cycles with no bubble, done after E0+8.
- repeat_n=0 with start -> busy, valid and done stay 0. start pulsed while busy with a new pattern 1100 -> output unchanged. start asserted in the done cycle -> new transmission's first bit after the next edge.
- abort at bit 2 of repetition 1, and separately during GAP -> next edge valid=0, busy=0, done never asserted. start with abort=1 in IDLE -> ignored.
- reset asserted mid-SEND together with start and abort -> all outputs 0 after the edge, state IDLE. A fresh start afterwards reproduces scenario 1 exactly.
